// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared memory / instruction definitions. Program memory and the fetch unit
// both import this package, so the address/data widths and the opcode layout
// stay consistent between them.
//   IF_ADDRESS_BITS : program address width
//   IF_DATA_BITS    : instruction word width
//   IF_OPCODE_BITS  : opcode field width (instruction MSBs)
//   IF_OPCODE_HLT   : opcode value of the halt instruction
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

   localparam int IF_ADDRESS_BITS = 11;
   localparam int IF_DATA_BITS    = 16;
   localparam int IF_OPCODE_BITS  = 5;

   // HLT is the all-zeros opcode; operand bits are don't-care.
   localparam logic [IF_OPCODE_BITS-1:0] IF_OPCODE_HLT = '0;

endpackage

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Sequential fetch unit: presents the PC to a synchronous program memory,
// captures the returned word and offers it downstream with a valid/ready
// handshake. One instruction per three cycles when downstream never stalls.
// Retiring a HLT instruction parks the unit until reset.
//
// Ports
//   clk             : clock, rising edge
//   rst             : asynchronous active-low reset
//   i_enable        : run enable
//   i_step          : single-step pulse (only with IF_SINGLE_STEP_EN)
//   o_mem_address   : program memory address (always the registered PC)
//   i_mem_data      : program memory data, valid one clock after the address
//   o_instr         : fetched instruction
//   o_valid         : o_instr valid
//   i_ready         : downstream accepts o_instr
//   i_branch        : override next PC on acceptance
//   i_branch_target : next PC when i_branch is set
//   o_pc            : address of o_instr
//   o_halted        : HLT retired
//   o_dbg_state     : current FSM state (debug visibility)
//
// Configuration
//   IF_SINGLE_STEP_EN : when defined, adds i_step; leaving IDLE needs
//                       i_enable and i_step together, and every retired
//                       non-HLT instruction returns to IDLE.
// -----------------------------------------------------------------------------
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int ADDRESS_BITS = IF_ADDRESS_BITS,
   parameter int DATA_BITS    = IF_DATA_BITS,
   parameter int OPCODE_BITS  = IF_OPCODE_BITS
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_enable,
`ifdef IF_SINGLE_STEP_EN
   input  logic                    i_step,
`endif
   output logic [ADDRESS_BITS-1:0] o_mem_address,
   input  logic [DATA_BITS-1:0]    i_mem_data,
   output logic [DATA_BITS-1:0]    o_instr,
   output logic                    o_valid,
   input  logic                    i_ready,
   input  logic                    i_branch,
   input  logic [ADDRESS_BITS-1:0] i_branch_target,
   output logic [ADDRESS_BITS-1:0] o_pc,
   output logic                    o_halted,
   output logic [2:0]              o_dbg_state
);

   // State encoding is private to this unit.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_ISSUE   = 3'd3,
      ST_HALTED  = 3'd4
   } state_t;

   state_t                  state_q,    state_d;
   logic [ADDRESS_BITS-1:0] pc_q,       pc_d;
   logic [ADDRESS_BITS-1:0] issue_pc_q, issue_pc_d;
   logic [DATA_BITS-1:0]    instr_q,    instr_d;
   logic                    valid_q,    valid_d;
   logic                    halted_q,   halted_d;

   logic                    accept;
   logic                    is_hlt;
   logic                    start_run;
   logic                    resume_run;
   logic [OPCODE_BITS-1:0]  opcode;
   logic [ADDRESS_BITS-1:0] pc_inc;

   // Handshake: o_valid rises when a word is captured and then o_instr/o_pc
   // hold steady until a cycle where o_valid && i_ready; that cycle is the
   // transfer. Branch inputs only matter in the transfer cycle.
   assign accept = (state_q == ST_ISSUE) && valid_q && i_ready;

   assign opcode = instr_q[DATA_BITS-1 -: OPCODE_BITS];
   assign is_hlt = (opcode == OPCODE_BITS'(IF_OPCODE_HLT));

   // Natural overflow of the ADDRESS_BITS-wide add wraps the top address to 0.
   assign pc_inc = pc_q + ADDRESS_BITS'(1);

`ifdef IF_SINGLE_STEP_EN
   assign start_run  = i_enable & i_step;
   assign resume_run = 1'b0;
`else
   assign start_run  = i_enable;
   assign resume_run = i_enable;
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      issue_pc_d = issue_pc_q;
      instr_d    = instr_q;
      valid_d    = valid_q;
      halted_d   = halted_q;
      case (state_q)
         ST_IDLE: begin
            if (start_run) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            // Memory is registering the word for pc_q during this cycle.
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            instr_d    = i_mem_data;
            issue_pc_d = pc_q;
            valid_d    = 1'b1;
            state_d    = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (accept) begin
               valid_d = 1'b0;
               if (is_hlt) begin
                  // PC is frozen at the HLT address.
                  halted_d = 1'b1;
                  state_d  = ST_HALTED;
               end else begin
                  pc_d    = i_branch ? i_branch_target : pc_inc;
                  state_d = resume_run ? ST_FETCH : ST_IDLE;
               end
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         issue_pc_q <= '0;
         instr_q    <= '0;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         issue_pc_q <= issue_pc_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
         halted_q   <= halted_d;
      end
   end

   assign o_mem_address = pc_q;
   assign o_instr       = instr_q;
   assign o_pc          = issue_pc_q;
   assign o_valid       = valid_q;
   assign o_halted      = halted_q;
   assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Self-checking bench for instruction_fetch. Program memory is a bench array
// read synchronously. Inputs change just after the falling edge and outputs
// are sampled on the falling edge. Define IF_SINGLE_STEP_EN to exercise the
// single-step build.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

   localparam int AW = 11;
   localparam int DW = 16;
   localparam int MEM_WORDS = 2048;
`ifdef IF_SINGLE_STEP_EN
   localparam int PERIOD = 4;
`else
   localparam int PERIOD = 3;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_enable = 1'b0;
   logic          i_ready = 1'b0;
   logic          i_branch = 1'b0;
   logic [AW-1:0] i_branch_target = '0;
   logic [DW-1:0] i_mem_data;
   logic [AW-1:0] o_mem_address;
   logic [AW-1:0] o_pc;
   logic [DW-1:0] o_instr;
   logic          o_valid;
   logic          o_halted;
   logic [2:0]    o_dbg_state;
`ifdef IF_SINGLE_STEP_EN
   logic          i_step = 1'b0;
`endif

   logic [DW-1:0]    mem [0:MEM_WORDS-1];
   logic [AW+DW-1:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [AW-1:0] start;
      logic [DW-1:0] instr;
      logic          br;
      logic [AW-1:0] tgt;
      logic          halt;
      logic [AW-1:0] next;
   } vec_t;
   vec_t vecs[7];

   // ---------------- clock / memory ----------------
   always #5 clk = ~clk;
   always @(posedge clk) i_mem_data <= mem[o_mem_address];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   instruction_fetch dut (
      .clk             (clk),
      .rst             (rst),
      .i_enable        (i_enable),
`ifdef IF_SINGLE_STEP_EN
      .i_step          (i_step),
`endif
      .o_mem_address   (o_mem_address),
      .i_mem_data      (i_mem_data),
      .o_instr         (o_instr),
      .o_valid         (o_valid),
      .i_ready         (i_ready),
      .i_branch        (i_branch),
      .i_branch_target (i_branch_target),
      .o_pc            (o_pc),
      .o_halted        (o_halted),
      .o_dbg_state     (o_dbg_state)
   );

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_run(input logic en);
      i_enable = en;
`ifdef IF_SINGLE_STEP_EN
      i_step = en;
`endif
   endtask

   task automatic apply_reset(input logic en);
      i_ready  = 1'b0;
      i_branch = 1'b0;
      set_run(en);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic wait_valid(input string name, input int budget, input bit rand_run);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         if (rand_run) set_run(1'($urandom_range(0, 1)));
         @(negedge clk);
         if (o_valid) ok = 1'b1;
      end
      if (rand_run) set_run(1'b1);
      check({name, "_timeout"}, 32'(ok), 32'd1);
   endtask

   task automatic accept(input logic br, input logic [AW-1:0] tgt);
      i_ready         = 1'b1;
      i_branch        = br;
      i_branch_target = tgt;
      @(negedge clk);
      i_ready         = 1'b0;
      i_branch        = 1'b0;
      i_branch_target = AW'($urandom);
   endtask

   // ---------------- test sequence ----------------
   int            exp_pc;
   int            last_c;
   int            idx;
   int            stalls;
   logic [AW+DW-1:0] e;
   logic          br;
   logic [AW-1:0] tgt;

   initial begin
      for (int i = 0; i < MEM_WORDS; i++)
         mem[i] = {5'($urandom_range(1, 31)), 11'($urandom)};
      mem[0] = 16'h0805;
      mem[1] = 16'h0811;

      vecs[0] = '{11'h010, 16'h0805, 1'b1, 11'h3F0, 1'b0, 11'h3F0};
      vecs[1] = '{11'h7FF, 16'h1234, 1'b0, 11'h155, 1'b0, 11'h000};
      vecs[2] = '{11'h100, 16'h0807, 1'b0, 11'h000, 1'b0, 11'h101};
      vecs[3] = '{11'h005, 16'h0000, 1'b1, 11'h3F0, 1'b1, 11'h000};
      vecs[4] = '{11'h020, 16'h07FF, 1'b0, 11'h000, 1'b1, 11'h000};
      vecs[5] = '{11'h021, 16'h0800, 1'b0, 11'h000, 1'b0, 11'h022};
      vecs[6] = '{11'h3F0, 16'hF800, 1'b1, 11'h7FF, 1'b0, 11'h7FF};

      // Reset values, asynchronous assertion, first fetch latency.
      set_run(1'b1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_valid",   32'(o_valid), 32'd0);
      check("rst_halted",  32'(o_halted), 32'd0);
      check("rst_instr",   32'(o_instr), 32'd0);
      check("rst_pc",      32'(o_pc), 32'd0);
      check("rst_address", 32'(o_mem_address), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("edge1_valid", 32'(o_valid), 32'd0);
      check("edge1_addr",  32'(o_mem_address), 32'd0);
      @(negedge clk);
      check("edge2_valid", 32'(o_valid), 32'd0);
      @(negedge clk);
      check("edge3_valid", 32'(o_valid), 32'd1);
      check("edge3_instr", 32'(o_instr), 32'h0805);
      check("edge3_pc",    32'(o_pc), 32'd0);

      // Stall in ISSUE for 5 cycles with noise on enable/branch.
      set_run(1'b0);
      i_branch = 1'b1;
      i_branch_target = 11'h155;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("stall_valid", 32'(o_valid), 32'd1);
         check("stall_instr", 32'(o_instr), 32'h0805);
         check("stall_pc",    32'(o_pc), 32'd0);
         check("stall_addr",  32'(o_mem_address), 32'd0);
      end
      set_run(1'b1);
      accept(1'b0, 11'h000);
      check("accept_valid", 32'(o_valid), 32'd0);
      check("accept_addr",  32'(o_mem_address), 32'd1);
      wait_valid("after_stall", 10, 1'b0);
      check("after_stall_pc",    32'(o_pc), 32'd1);
      check("after_stall_instr", 32'(o_instr), 32'h0811);

      // Throughput with ready held high.
      i_ready = 1'b1;
      idx = 0;
      last_c = 0;
      for (int c = 0; c < 13; c++) begin
         if (o_valid) begin
            if (idx > 0) check("throughput", 32'(c - last_c), 32'(PERIOD));
            check("tp_pc", 32'(o_pc), 32'(1 + idx));
            last_c = c;
            idx++;
         end
         @(negedge clk);
      end
      i_ready = 1'b0;

      // Table-driven acceptance vectors.
      for (int v = 0; v < 7; v++) begin
         mem[vecs[v].start] = vecs[v].instr;
         apply_reset(1'b1);
         wait_valid("vec_first", 10, 1'b0);
         accept(1'b1, vecs[v].start);
         wait_valid("vec_start", 10, 1'b0);
         check("vec_pc",    32'(o_pc), 32'(vecs[v].start));
         check("vec_instr", 32'(o_instr), 32'(vecs[v].instr));
         accept(vecs[v].br, vecs[v].tgt);
         if (vecs[v].halt) begin
            check("vec_halted", 32'(o_halted), 32'd1);
            check("vec_halt_valid", 32'(o_valid), 32'd0);
         end else begin
            check("vec_not_halted", 32'(o_halted), 32'd0);
            wait_valid("vec_next", 10, 1'b0);
            check("vec_next_pc",    32'(o_pc), 32'(vecs[v].next));
            check("vec_next_instr", 32'(o_instr), 32'(mem[vecs[v].next]));
         end
      end

      // HLT is permanent whatever the inputs do.
      mem[11'h040] = 16'h0000;
      apply_reset(1'b1);
      wait_valid("hlt_first", 10, 1'b0);
      accept(1'b1, 11'h040);
      wait_valid("hlt_issue", 10, 1'b0);
      accept(1'b1, 11'h3F0);
      i_ready  = 1'b1;
      i_branch = 1'b1;
      for (int c = 0; c < 20; c++) begin
         i_branch_target = AW'($urandom);
         @(negedge clk);
         check("hlt_halted", 32'(o_halted), 32'd1);
         check("hlt_valid",  32'(o_valid), 32'd0);
         check("hlt_addr",   32'(o_mem_address), 32'h040);
      end
      i_ready  = 1'b0;
      i_branch = 1'b0;

      // Reset asserted in ISSUE at pc 5.
      mem[5] = 16'h0805;
      apply_reset(1'b1);
      wait_valid("midrst_first", 10, 1'b0);
      accept(1'b1, 11'h005);
      wait_valid("midrst_issue", 10, 1'b0);
      check("midrst_pc_before", 32'(o_pc), 32'd5);
      #2 rst = 1'b0;
      #1;
      check("midrst_valid", 32'(o_valid), 32'd0);
      check("midrst_pc",    32'(o_pc), 32'd0);
      check("midrst_addr",  32'(o_mem_address), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      wait_valid("midrst_restart", 10, 1'b0);
      check("midrst_restart_pc",    32'(o_pc), 32'd0);
      check("midrst_restart_instr", 32'(o_instr), 32'h0805);

      // Randomized run against a transaction-level model.
      for (int i = 0; i < 4; i++) mem[11'h040 + i] = {5'b00000, 11'($urandom)};
      apply_reset(1'b1);
      exp_pc = 0;
      exp_q.delete();
      for (int k = 0; k < 80; k++) begin
         exp_q.push_back({AW'(exp_pc), mem[exp_pc]});
         wait_valid("rnd_issue", 60, 1'b1);
         e = exp_q.pop_front();
         if (!o_valid) begin
            apply_reset(1'b1);
            exp_pc = 0;
            continue;
         end
         check("rnd_pc",    32'(o_pc), 32'(e[AW+DW-1:DW]));
         check("rnd_instr", 32'(o_instr), 32'(e[DW-1:0]));
         stalls = $urandom_range(0, 3);
         for (int s = 0; s < stalls; s++) begin
            i_branch = 1'($urandom);
            i_branch_target = AW'($urandom);
            set_run(1'($urandom_range(0, 1)));
            @(negedge clk);
            check("rnd_hold", 32'({o_valid, o_pc, o_instr}), 32'({1'b1, e}));
         end
         br = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       tgt = AW'(11'h040 + $urandom_range(0, 7));
            1:       tgt = 11'h7FF;
            default: tgt = AW'($urandom);
         endcase
         accept(br, tgt);
         if (mem[exp_pc][15:11] == 5'b00000) begin
            check("rnd_halt", 32'({o_halted, o_valid}), 32'b10);
            apply_reset(1'b1);
            exp_pc = 0;
         end else begin
            check("rnd_not_halted", 32'(o_halted), 32'd0);
            exp_pc = br ? int'(tgt) : (exp_pc + 1) % MEM_WORDS;
         end
      end
      i_ready = 1'b0;

`ifdef IF_SINGLE_STEP_EN
      // Single step: enable alone does nothing, each pulse issues one word.
      apply_reset(1'b0);
      i_enable = 1'b1;
      i_step   = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("step_idle_valid", 32'(o_valid), 32'd0);
      end
      i_enable = 1'b0;
      i_step   = 1'b1;
      repeat (4) @(negedge clk);
      check("step_noenable_valid", 32'(o_valid), 32'd0);
      check("step_noenable_addr",  32'(o_mem_address), 32'd0);
      i_enable = 1'b1;
      i_step   = 1'b1;
      @(negedge clk);
      i_step   = 1'b0;
      wait_valid("step_issue", 10, 1'b0);
      check("step_pc", 32'(o_pc), 32'd0);
      accept(1'b0, 11'h000);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check("step_after_valid", 32'(o_valid), 32'd0);
         check("step_after_addr",  32'(o_mem_address), 32'd1);
      end
      i_step = 1'b1;
      @(negedge clk);
      i_step = 1'b0;
      wait_valid("step_second", 10, 1'b0);
      check("step_second_pc", 32'(o_pc), 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
